turn_sequencer: RTL
===================

// Module: turn_sequencer
// PURPOSE
//  Owns the 256-cell game board register and sequences each move: accepts a place
//  request, rejects occupied cells, writes the stone, then resets, starts and waits on
//  the five-in-a-row win checker (overall_check). Alternates players, detects win or
//  draw, and holds game-over until a new game is started.
//  Sits between the player input/cursor logic and overall_check. Drives its board,
//  pointer, chess, go and reset inputs.
// PARAMETERS
//  FIRST_CHESS  2'b01  colour that moves first after reset/new_game (2'b01 or 2'b10)
//  TIMEOUT      1023   max cycles in CHK_WAIT before the move is forced to "no win"
//  CELLS        256    board cells (2 bits each); board width = 2*CELLS
// PORTS
//  clk          in   1    system clock, all state on posedge
//  resetn       in   1    asynchronous active-low reset
//  place        in   1    player place key (level); a move is taken on its rising edge
//  new_game     in   1    synchronous clear of board/turn/result; wins over everything
//  pointer      in   8    cursor cell index, sampled on the accepted place edge
//  chk_success  in   1    checker final_suc (five in a row found)
//  chk_fail     in   1    checker final_fai (all four directions checked, no five)
//  board        out  512  board image; cell i = board[2i+1:2i], 00 empty/01 P1/10 P2
//  chk_pointer  out  8    latched move cell to checker
//  chk_chess    out  2    colour of the move under check
//  chk_go       out  1    one-cycle start pulse to checker (its active input)
//  chk_reset    out  1    one-cycle active-high checker reset
//  cur_chess    out  2    colour to move next
//  busy         out  1    high in every state except IDLE and OVER
//  reject       out  1    one-cycle pulse: requested cell occupied
//  game_over    out  1    high in OVER
//  winner       out  2    winning colour; 00 = draw or none
//  timeout_err  out  1    sticky: a check hit TIMEOUT; cleared by new_game/reset
// BEHAVIOUR
//  Reset (resetn=0): state=IDLE, board=0, cur_chess=FIRST_CHESS, move_cnt=0,
//   winner=00, game_over=0, timeout_err=0, every pulse output=0, place_q=0.
//   chk_pointer/chk_chess reset to 0.
//  place edge detect: place_q<=place every cycle; edge = place & ~place_q. Edges
//   outside IDLE are dropped, never queued.
//  FSM (one state per cycle unless noted):
//   IDLE:     edge -> ptr_q<=pointer, go VALIDATE.
//   VALIDATE: cell[ptr_q]!=00 -> reject=1 this cycle, go IDLE. Else go WRITE.
//   WRITE:    cell[ptr_q]<=cur_chess. chk_pointer<=ptr_q; chk_chess<=cur_chess. Go CHK_RST.
//   CHK_RST:  chk_reset=1. Go CHK_GO.
//   CHK_GO:   chk_go=1. Clear timer. Go CHK_WAIT.
//   CHK_WAIT: timer++.
//    chk_success -> winner<=chk_chess, go OVER. Success wins if both are high.
//    else chk_fail -> go TURN.
//    else timer==TIMEOUT -> timeout_err<=1, go TURN.
//   TURN:     cur_chess<=~cur_chess (01<->10); move_cnt<=move_cnt+1 (9 bits).
//    New count == CELLS -> winner<=00, go OVER (draw). Else go IDLE.
//   OVER:     game_over=1; stays until new_game.
//  new_game in any state: next cycle state=IDLE, with the reset values above.
//   Exception: place_q keeps tracking place.
//  chk_pointer/chk_chess stay stable from WRITE+1 until the next WRITE.
//  Latency: place edge sampled in cycle 0 (IDLE). WRITE is cycle 2. New board is
//   visible cycle 3 (CHK_RST). chk_go is cycle 4. Earliest result seen is cycle 5.
//  The only board write path is WRITE; occupied cells are never overwritten.
// TESTING
//  1 Reset, place edge ptr=8'd17 -> board[35:34]=01 at cycle 3; chk_reset@3, chk_go@4,
//    chk_pointer=17. chk_fail@6 -> cur_chess=10, busy=0.
//  2 Place on occupied cell 17 -> reject=1 for exactly 1 cycle, board unchanged,
//    cur_chess unchanged, move_cnt unchanged.
//  3 P1 move, checker returns chk_success -> game_over=1, winner=01.
//    Later place edges ignored; new_game -> board=0, cur_chess=01, game_over=0.
//  4 Checker never answers -> after TIMEOUT cycles in CHK_WAIT: timeout_err=1,
//    turn passes to P2.
//  5 Fill all 256 cells with chk_fail every time -> after 256th TURN game_over=1,
//    winner=00.
//  6 place held high for 20 cycles -> exactly one move. resetn low mid CHK_WAIT ->
//    all outputs at reset values immediately.

Source files
------------

// File: rtl/turn_sequencer.sv
// turn_sequencer: owns the 256-cell board, sequences each move through the win checker.
// Latency: place edge in cycle 0, board written in cycle 2 (visible 3), chk_go in cycle 4.
// Backpressure: place edges outside IDLE are dropped, never queued; OVER holds until new_game.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   place, pointer              player place key (rising edge = move request) and cursor cell
//   new_game                    synchronous clear of board/turn/result, highest priority
//   chk_success, chk_fail       win checker results (five found / all directions clean)
//   board                       board image, cell i = board[2i+1:2i] (00 empty, 01 P1, 10 P2)
//   chk_pointer, chk_chess      latched move cell and colour for the checker
//   chk_go, chk_reset           one-cycle start / reset pulses to the checker
//   cur_chess                   colour to move next
//   busy, reject, game_over     sequencing status; reject pulses on an occupied cell
//   winner, timeout_err         result colour (00 draw/none); sticky checker timeout flag
module turn_sequencer #(
  parameter logic [1:0] FIRST_CHESS = 2'b01,
  parameter int         TIMEOUT     = 1023,
  parameter int         CELLS       = 256
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 place,
  input  logic                 new_game,
  input  logic [7:0]           pointer,
  input  logic                 chk_success,
  input  logic                 chk_fail,
  output logic [2*CELLS-1:0]   board,
  output logic [7:0]           chk_pointer,
  output logic [1:0]           chk_chess,
  output logic                 chk_go,
  output logic                 chk_reset,
  output logic [1:0]           cur_chess,
  output logic                 busy,
  output logic                 reject,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic                 timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_VALIDATE = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_CHK_RST  = 3'd3;
  localparam logic [2:0] S_CHK_GO   = 3'd4;
  localparam logic [2:0] S_CHK_WAIT = 3'd5;
  localparam logic [2:0] S_TURN     = 3'd6;
  localparam logic [2:0] S_OVER     = 3'd7;

  logic [2:0]         r_state;
  logic [2*CELLS-1:0] r_board;
  logic [7:0]         r_ptr;
  logic [7:0]         r_chk_ptr;
  logic [1:0]         r_chk_chess;
  logic [1:0]         r_cur;
  logic [8:0]         r_cnt;
  logic [1:0]         r_winner;
  logic               r_timeout_err;
  logic [TW-1:0]      r_timer;
  logic               r_place_q;

  logic               w_place_edge;
  logic [1:0]         w_cell;
  logic               w_cell_taken;
  logic [8:0]         w_cnt_next;

  assign w_place_edge = place & ~r_place_q;
  assign w_cell       = r_board[{r_ptr, 1'b0} +: 2];
  assign w_cell_taken = (w_cell != 2'b00);
  assign w_cnt_next   = r_cnt + 9'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_board       <= '0;
      r_ptr         <= '0;
      r_chk_ptr     <= '0;
      r_chk_chess   <= 2'b00;
      r_cur         <= FIRST_CHESS;
      r_cnt         <= '0;
      r_winner      <= 2'b00;
      r_timeout_err <= 1'b0;
      r_timer       <= '0;
      r_place_q     <= 1'b0;
    end else begin
      // Edge detector keeps tracking place even across new_game, so a key
      // already held down when the game is cleared does not count as a move.
      r_place_q <= place;
      if (new_game) begin
        r_state       <= S_IDLE;
        r_board       <= '0;
        r_ptr         <= '0;
        r_chk_ptr     <= '0;
        r_chk_chess   <= 2'b00;
        r_cur         <= FIRST_CHESS;
        r_cnt         <= '0;
        r_winner      <= 2'b00;
        r_timeout_err <= 1'b0;
        r_timer       <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_place_edge) begin
              r_ptr   <= pointer;
              r_state <= S_VALIDATE;
            end
          end
          S_VALIDATE: begin
            r_state <= w_cell_taken ? S_IDLE : S_WRITE;
          end
          S_WRITE: begin
            r_board[{r_ptr, 1'b0} +: 2] <= r_cur;
            r_chk_ptr   <= r_ptr;
            r_chk_chess <= r_cur;
            r_state     <= S_CHK_RST;
          end
          S_CHK_RST: begin
            r_state <= S_CHK_GO;
          end
          S_CHK_GO: begin
            r_timer <= '0;
            r_state <= S_CHK_WAIT;
          end
          S_CHK_WAIT: begin
            r_timer <= r_timer + 1'b1;
            // Success takes priority over fail when the checker raises both.
            if (chk_success) begin
              r_winner <= r_chk_chess;
              r_state  <= S_OVER;
            end else if (chk_fail) begin
              r_state <= S_TURN;
            end else if (r_timer == TW'(TIMEOUT)) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_TURN;
            end
          end
          S_TURN: begin
            r_cur <= ~r_cur;
            r_cnt <= w_cnt_next;
            if (w_cnt_next == 9'(CELLS)) begin
              r_winner <= 2'b00;
              r_state  <= S_OVER;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_OVER: begin
            r_state <= S_OVER;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Pulse and status outputs are pure state decodes, so an asynchronous
  // reset drops them in the same instant as the state register.
  assign board       = r_board;
  assign chk_pointer = r_chk_ptr;
  assign chk_chess   = r_chk_chess;
  assign chk_reset   = (r_state == S_CHK_RST);
  assign chk_go      = (r_state == S_CHK_GO);
  assign cur_chess   = r_cur;
  assign busy        = (r_state != S_IDLE) && (r_state != S_OVER);
  assign reject      = (r_state == S_VALIDATE) && w_cell_taken;
  assign game_over   = (r_state == S_OVER);
  assign winner      = r_winner;
  assign timeout_err = r_timeout_err;

endmodule
